// File: rtl/pm_pkg.sv
// ============================================================================
// pm_pkg -- shared state encoding and default sizing for period_meter
// Revision: 1.0
// ============================================================================
`default_nettype none

package pm_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEF_COUNT_W = 32;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_LOCK_N  = 4;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
// edge_sync -- 2-flop synchronizer with registered rise/fall detection
// Revision: 1.0
// ============================================================================
`default_nettype none

module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s_d;

  // level is the delayed copy so that it changes on the same edge as rise/fall
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s_d  <= s2;
      rise <= s2 & ~s_d;
      fall <= ~s2 & s_d;
    end
  end

  assign level = s_d;

endmodule

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// period_meter -- measures period/high time of sig_in in clk cycles, with
//                 lock detection and sticky no-edge timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module period_meter
  import pm_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int LOCK_N  = DEF_LOCK_N,
  parameter int TOL     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] period,
  output logic [COUNT_W-1:0] high_time,
  output logic               period_valid,
  output logic               locked,
  output logic               timeout
);

  localparam int                 LOCK_W    = $clog2(LOCK_N + 1);
  localparam logic [COUNT_W-1:0] TIMEOUT_C = COUNT_W'(TIMEOUT);
  localparam logic [COUNT_W-1:0] TOL_C     = COUNT_W'(TOL);
  localparam logic [LOCK_W-1:0]  LOCK_C    = LOCK_W'(LOCK_N);

  if (TIMEOUT < 1 || (COUNT_W < 31 && TIMEOUT >= (1 << COUNT_W))) begin : g_timeout_range
    $error("period_meter: TIMEOUT does not fit in COUNT_W bits");
  end

  logic               level;
  logic               rise;
  logic               fall;
  state_t             state_q;
  state_t             state_d;
  logic               start;
  logic               measure;
  logic               expire;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] hi_cnt;
  logic [COUNT_W-1:0] diff;
  logic               match;
  logic               have_prev;
  logic [LOCK_W-1:0]  lock_cnt;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sig_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A rise on the terminal count wins over the timeout
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    measure = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          start   = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          measure = 1'b1;
        end else if (cnt == TIMEOUT_C) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    diff  = (cnt >= period) ? (cnt - period) : (period - cnt);
    match = (diff <= TOL_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      hi_cnt       <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      have_prev    <= 1'b0;
      lock_cnt     <= '0;
    end else begin
      period_valid <= 1'b0;
      if (start) begin
        cnt    <= COUNT_W'(1);
        hi_cnt <= COUNT_W'(1);
      end else if (measure) begin
        cnt          <= COUNT_W'(1);
        hi_cnt       <= COUNT_W'(1);
        period       <= cnt;
        high_time    <= hi_cnt;
        period_valid <= 1'b1;
        timeout      <= 1'b0;
        have_prev    <= 1'b1;
        if (have_prev) begin
          if (match) begin
            if (lock_cnt < LOCK_C) lock_cnt <= lock_cnt + LOCK_W'(1);
            if (lock_cnt >= LOCK_C - LOCK_W'(1)) locked <= 1'b1;
          end else begin
            lock_cnt <= '0;
            locked   <= 1'b0;
          end
        end
      end else if (expire) begin
        cnt       <= '0;
        timeout   <= 1'b1;
        locked    <= 1'b0;
        lock_cnt  <= '0;
        have_prev <= 1'b0;
      end else if (state_q == MEASURE) begin
        cnt <= cnt + COUNT_W'(1);
        // While still high, hi_cnt tracks the count so a missing fall publishes the full period
        if (fall)       hi_cnt <= cnt;
        else if (level) hi_cnt <= cnt + COUNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: one instance at default sizing, one with
// TIMEOUT=20 / LOCK_N=2 / TOL=1 for terminal-count and tolerance cases.
`default_nettype none

module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_a = 1'b0;
  logic        sig_b = 1'b0;
  logic [31:0] period_a, high_a;
  logic        pv_a, locked_a, to_a;
  logic [15:0] period_b, high_b;
  logic        pv_b, locked_b, to_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pv_a_n = 0;
  int pv_b_n = 0;
  int last_a = 0;
  int gap_a = 0;

  always #5 clk = ~clk;

  period_meter #(.COUNT_W(32), .TIMEOUT(1000), .LOCK_N(4), .TOL(0)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_a), .period(period_a), .high_time(high_a),
    .period_valid(pv_a), .locked(locked_a), .timeout(to_a)
  );

  period_meter #(.COUNT_W(16), .TIMEOUT(20), .LOCK_N(2), .TOL(1)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .period(period_b), .high_time(high_b),
    .period_valid(pv_b), .locked(locked_b), .timeout(to_b)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pv_a === 1'b1) begin
      pv_a_n++;
      gap_a  = cyc - last_a;
      last_a = cyc;
    end
    if (pv_b === 1'b1) pv_b_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sig period: hi cycles high then lo cycles low, starting with a rise
  task automatic drive(input int which, input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin
      if (which == 0) sig_a = 1'b1; else sig_b = 1'b1;
      step();
    end
    for (int i = 0; i < lo; i++) begin
      if (which == 0) sig_a = 1'b0; else sig_b = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (period_a !== 32'd0 || high_a !== 32'd0) begin failures++; $display("FAIL reset_a_counts actual=%0d/%0d required=0/0", period_a, high_a); end
    checks++; if ({pv_a, locked_a, to_a} !== 3'b000) begin failures++; $display("FAIL reset_a_flags actual=%b required=000", {pv_a, locked_a, to_a}); end
    checks++; if (period_b !== 16'd0 || {pv_b, locked_b, to_b} !== 3'b000) begin failures++; $display("FAIL reset_b actual=%0d/%b required=0/000", period_b, {pv_b, locked_b, to_b}); end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_latency();
    int bad;
    drive(0, 4, 4);
    checks++; if (pv_a_n !== 0) begin failures++; $display("FAIL first_rise_no_pulse actual=%0d required=0", pv_a_n); end
    bad = 0;
    sig_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (pv_a !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL latency_early actual=%0d required=0", bad); end
    step();
    checks++; if (pv_a !== 1'b1) begin failures++; $display("FAIL latency_4 actual=%b required=1", pv_a); end
    checks++; if (period_a !== 32'd8 || high_a !== 32'd4) begin failures++; $display("FAIL first_meas actual=%0d/%0d required=8/4", period_a, high_a); end
    sig_a = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_lock();
    for (int i = 0; i < 3; i++) drive(0, 4, 4);
    checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL lock_pv4 actual=%b required=0", locked_a); end
    drive(0, 4, 4);
    checks++; if (locked_a !== 1'b1 || pv_a_n !== 5) begin failures++; $display("FAIL lock_pv5 actual=%b/%0d required=1/5", locked_a, pv_a_n); end
    checks++; if (gap_a !== 8) begin failures++; $display("FAIL pv_spacing actual=%0d required=8", gap_a); end
    drive(0, 6, 4);
    checks++; if (locked_a !== 1'b1 || period_a !== 32'd8) begin failures++; $display("FAIL pre_stretch actual=%b/%0d required=1/8", locked_a, period_a); end
    drive(0, 4, 4);
    checks++; if (period_a !== 32'd10 || high_a !== 32'd6 || locked_a !== 1'b0) begin failures++; $display("FAIL stretch actual=%0d/%0d/%b required=10/6/0", period_a, high_a, locked_a); end
    // first 8 after the 10 is itself a mismatch; four matches follow
    for (int i = 0; i < 4; i++) drive(0, 4, 4);
    checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL relock_early actual=%b required=0", locked_a); end
    drive(0, 4, 4);
    checks++; if (locked_a !== 1'b1 || period_a !== 32'd8) begin failures++; $display("FAIL relock actual=%b/%0d required=1/8", locked_a, period_a); end
  endtask

  task automatic test_timeout();
    int bad;
    int n0;
    bad = 0;
    // 8 cycles already elapsed since the last rise was driven; expiry lands 1004 after it
    for (int i = 0; i < 995; i++) begin
      step();
      if (to_a !== 1'b0 || locked_a !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL timeout_early actual=%0d required=0", bad); end
    step();
    checks++; if (to_a !== 1'b1 || locked_a !== 1'b0) begin failures++; $display("FAIL timeout_set actual=%b/%b required=1/0", to_a, locked_a); end
    checks++; if (period_a !== 32'd8 || high_a !== 32'd4) begin failures++; $display("FAIL timeout_hold actual=%0d/%0d required=8/4", period_a, high_a); end
    n0 = pv_a_n;
    drive(0, 4, 4);
    checks++; if (pv_a_n !== n0 || to_a !== 1'b1) begin failures++; $display("FAIL reentry_no_pulse actual=%0d/%b required=%0d/1", pv_a_n, to_a, n0); end
    drive(0, 4, 4);
    checks++; if (pv_a_n !== n0 + 1 || to_a !== 1'b0 || period_a !== 32'd8 || locked_a !== 1'b0) begin failures++; $display("FAIL timeout_clear actual=%0d/%b/%0d/%b required=%0d/0/8/0", pv_a_n, to_a, period_a, locked_a, n0 + 1); end
  endtask

  task automatic test_duty();
    drive(0, 3, 7);
    drive(0, 3, 7);
    checks++; if (period_a !== 32'd10 || high_a !== 32'd3) begin failures++; $display("FAIL duty_3_7 actual=%0d/%0d required=10/3", period_a, high_a); end
  endtask

  task automatic test_reset_mid();
    int n0;
    sig_a = 1'b1;
    repeat (3) step();
    sig_a = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    checks++; if (period_a !== 32'd0 || high_a !== 32'd0 || {pv_a, locked_a, to_a} !== 3'b000) begin failures++; $display("FAIL mid_reset actual=%0d/%0d/%b required=0/0/000", period_a, high_a, {pv_a, locked_a, to_a}); end
    rst = 1'b0;
    n0 = pv_a_n;
    drive(0, 4, 4);
    checks++; if (pv_a_n !== n0) begin failures++; $display("FAIL post_reset_first actual=%0d required=%0d", pv_a_n, n0); end
    drive(0, 4, 4);
    checks++; if (pv_a_n !== n0 + 1 || period_a !== 32'd8 || high_a !== 32'd4) begin failures++; $display("FAIL post_reset_meas actual=%0d/%0d/%0d required=%0d/8/4", pv_a_n, period_a, high_a, n0 + 1); end
  endtask

  task automatic test_timeout_edge();
    int n0;
    for (int i = 0; i < 3; i++) drive(1, 10, 10);
    checks++; if (pv_b_n !== 2 || period_b !== 16'd20 || to_b !== 1'b0) begin failures++; $display("FAIL edge_rise_wins actual=%0d/%0d/%b required=2/20/0", pv_b_n, period_b, to_b); end
    checks++; if (locked_b !== 1'b0) begin failures++; $display("FAIL b_lock_early actual=%b required=0", locked_b); end
    drive(1, 10, 11);
    checks++; if (locked_b !== 1'b1 || to_b !== 1'b0) begin failures++; $display("FAIL b_lock actual=%b/%b required=1/0", locked_b, to_b); end
    n0 = pv_b_n;
    drive(1, 5, 5);
    checks++; if (to_b !== 1'b1 || locked_b !== 1'b0 || pv_b_n !== n0 || period_b !== 16'd20) begin failures++; $display("FAIL b_timeout actual=%b/%b/%0d/%0d required=1/0/%0d/20", to_b, locked_b, pv_b_n, period_b, n0); end
  endtask

  task automatic test_tolerance();
    drive(1, 6, 5);
    checks++; if (period_b !== 16'd10 || high_b !== 16'd5 || to_b !== 1'b0 || locked_b !== 1'b0) begin failures++; $display("FAIL tol_first actual=%0d/%0d/%b/%b required=10/5/0/0", period_b, high_b, to_b, locked_b); end
    drive(1, 5, 5);
    checks++; if (period_b !== 16'd11 || high_b !== 16'd6 || locked_b !== 1'b0) begin failures++; $display("FAIL tol_within actual=%0d/%0d/%b required=11/6/0", period_b, high_b, locked_b); end
    drive(1, 5, 5);
    checks++; if (period_b !== 16'd10 || locked_b !== 1'b1) begin failures++; $display("FAIL tol_lock actual=%0d/%b required=10/1", period_b, locked_b); end
    drive(1, 5, 8);
    drive(1, 5, 5);
    checks++; if (period_b !== 16'd13 || locked_b !== 1'b0) begin failures++; $display("FAIL tol_exceed actual=%0d/%b required=13/0", period_b, locked_b); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_lock();
    test_timeout();
    test_duty();
    test_reset_mid();
    test_timeout_edge();
    test_tolerance();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
